btn_servo_ctrl: RTL and testbench
=================================

BTN_SERVO_CTRL -- requirements
Module: btn_servo_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): STEP, 8, position increment per button pulse; POS_MIN, 0, lower position limit; POS_MAX, 180, upper position limit; CENTER, 90, position loaded on entry to manual mode.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- i_btn_up / i_btn_down  in  1 each  single-cycle debounced pulses for tilt +/-.
- i_btn_left / i_btn_right  in  1 each  single-cycle debounced pulses for pan -/+.
- i_btn_mode  in  1  single-cycle debounced pulse that toggles AUTO/MANUAL.
- i_ready  in  1  downstream servo driver accepts the command.
- o_valid  out  1  command valid.
- o_pan / o_tilt  out  8 each  commanded positions.
- o_mode  out  1  0 = AUTO, 1 = MANUAL.
- o_cmd_cnt  out  8  count of accepted commands.
REQ-003 The design SHALL use one clock (clk) and one reset; reset SHALL be asynchronous and active-low (reset = 0 resets).

Function
REQ-004 The FSM SHALL have three states: AUTO, MANUAL and SEND. o_mode SHALL be 0 in AUTO and 1 in MANUAL and SEND.
REQ-005 In AUTO, direction pulses SHALL be ignored and not stored.
REQ-006 In AUTO, an i_btn_mode pulse SHALL load o_pan = o_tilt = CENTER and move to SEND on the next edge.
REQ-007 In MANUAL, an i_btn_mode pulse SHALL move to AUTO, clear all pending flags and issue no command. It SHALL take priority over direction pulses in the same cycle, which are then discarded.
REQ-008 In MANUAL, the effective pulses SHALL be the input pulses ORed with the pending flags.
- up+down both active: tilt unchanged.
- left+right both active: pan unchanged.
- Otherwise tilt is +/- STEP and pan is +/- STEP.
REQ-009 Arithmetic SHALL use 9-bit intermediates and saturate: a result > POS_MAX gives POS_MAX, and a result < POS_MIN (including underflow) gives POS_MIN.
REQ-010 If the new pan or tilt differs from the current value, the FSM SHALL register it and enter SEND on the next edge. Otherwise it SHALL stay in MANUAL with no command.
REQ-011 Pending flags SHALL clear on the edge where they are consumed.
REQ-012 Latency: a pulse in MANUAL at cycle N SHALL produce updated o_pan/o_tilt with o_valid = 1 at cycle N+1.
REQ-013 In SEND, o_valid SHALL be 1, and o_pan/o_tilt SHALL be held stable until the cycle where o_valid & i_ready.
REQ-014 On the cycle where o_valid & i_ready, the FSM SHALL return to MANUAL and o_cmd_cnt SHALL increment, wrapping from 255 to 0.
REQ-015 Direction pulses in SEND, including on the handshake cycle, SHALL set per-direction sticky pending flags; a repeat pulse in the same direction SHALL not accumulate.
REQ-016 An i_btn_mode pulse in SEND SHALL set a pending-mode flag. After the handshake it SHALL be processed in MANUAL with REQ-007 priority.
REQ-017 o_valid SHALL be 0 in AUTO and MANUAL. o_valid SHALL never deassert in SEND without i_ready.
REQ-018 o_pan/o_tilt SHALL retain their last values in AUTO.

Reset
REQ-019 While reset = 0, the following SHALL hold immediately: state = AUTO, o_valid = 0, o_mode = 0, o_pan = o_tilt = CENTER, o_cmd_cnt = 0, all pending flags cleared.
REQ-020 Reset during SEND SHALL abort the command without incrementing o_cmd_cnt.
REQ-021 On reset release, the first clk edge SHALL operate normally.

Verification
REQ-022 Mode entry: reset, i_btn_mode pulse, i_ready = 1. Expect o_valid = 1 next cycle, pan = tilt = 90, o_cmd_cnt = 1, then o_mode = 1, o_valid = 0.
REQ-023 Saturation: in MANUAL, 12 right pulses each handshaken. Expect pan 98, 106, ..., 178, 180. A further right pulse produces no o_valid and pan stays 180.
REQ-024 Backpressure: i_ready = 0, up pulse (tilt 98), then up and left pulses during SEND. Outputs stay 98/90 until i_ready = 1, then the next command is tilt 106 / pan 82 two cycles later.
REQ-025 Simultaneous events: up+down in the same cycle produces no command. mode+right in the same cycle in MANUAL goes to AUTO, pan unchanged, o_valid = 0.
REQ-026 Reset mid-SEND: hold i_ready = 0, assert reset. Expect o_valid = 0, pan = tilt = 90, o_cmd_cnt = 0, o_mode = 0.
REQ-027 Counter wrap: 256 accepted commands return o_cmd_cnt to 0.

Source files
------------

// File: rtl/btn_servo_ctrl.sv
// ---------------------------------------------------------------------------
// btn_servo_ctrl
//   Converts debounced push-button pulses into pan/tilt position commands
//   for a downstream servo driver. Commands use a valid/ready handshake.
//   Direction presses that arrive while a command is in flight are kept as
//   sticky pending flags. They are applied once the driver has accepted the
//   current command.
//
// Ports
//   clk          system clock (100 MHz)
//   reset        asynchronous, active-low reset
//   i_btn_up     tilt + pulse          i_btn_down   tilt - pulse
//   i_btn_left   pan  - pulse          i_btn_right  pan  + pulse
//   i_btn_mode   AUTO/MANUAL toggle pulse
//   i_ready      driver accepts the current command
//   o_valid      command valid (only in SEND)
//   o_pan/o_tilt commanded positions
//   o_mode       0 = AUTO, 1 = MANUAL (also 1 while sending)
//   o_cmd_cnt    count of accepted commands, wraps at 256
//
// State   | meaning
// --------+------------------------------------------------------------
// AUTO    | buttons other than mode ignored; positions held
// MANUAL  | apply presses (plus pending flags); send on any change
// SEND    | o_valid high, positions frozen until i_ready; presses pend
// ---------------------------------------------------------------------------
module btn_servo_ctrl #(
    parameter int STEP    = 8,
    parameter int POS_MIN = 0,
    parameter int POS_MAX = 180,
    parameter int CENTER  = 90
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_btn_left,
    input  logic       i_btn_right,
    input  logic       i_btn_mode,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [7:0] o_pan,
    output logic [7:0] o_tilt,
    output logic       o_mode,
    output logic [7:0] o_cmd_cnt
);

    localparam logic [8:0] STEP9    = 9'(STEP);
    localparam logic [8:0] POS_MIN9 = 9'(POS_MIN);
    localparam logic [8:0] POS_MAX9 = 9'(POS_MAX);
    localparam logic [7:0] POS_MIN8 = 8'(POS_MIN);
    localparam logic [7:0] POS_MAX8 = 8'(POS_MAX);
    localparam logic [7:0] CENTER8  = 8'(CENTER);

    typedef enum logic [1:0] {
        ST_AUTO   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pan_q, pan_d;
    logic [7:0] tilt_q, tilt_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_up_q, pend_up_d;
    logic       pend_down_q, pend_down_d;
    logic       pend_left_q, pend_left_d;
    logic       pend_right_q, pend_right_d;
    logic       pend_mode_q, pend_mode_d;

    logic       eff_up, eff_down, eff_left, eff_right, eff_mode;
    logic [7:0] pan_next, tilt_next;

    // One step in the requested direction. Opposing requests cancel.
    // The current position is always inside [POS_MIN, POS_MAX], so an
    // increment only needs the upper clamp and a decrement only the lower
    // one. Bit 8 of the 9-bit difference is set when the subtraction
    // borrows, i.e. the result would go below zero.
    function automatic logic [7:0] step_pos(input logic [7:0] pos,
                                            input logic       inc,
                                            input logic       dec);
        logic [8:0] sum;
        logic [8:0] diff;
        sum  = {1'b0, pos} + STEP9;
        diff = {1'b0, pos} - STEP9;
        if (inc && !dec) begin
            if (sum >= POS_MAX9) return POS_MAX8;
            return sum[7:0];
        end
        if (dec && !inc) begin
            if (diff[8] || (diff <= POS_MIN9)) return POS_MIN8;
            return diff[7:0];
        end
        return pos;
    endfunction

    assign eff_up    = i_btn_up    | pend_up_q;
    assign eff_down  = i_btn_down  | pend_down_q;
    assign eff_left  = i_btn_left  | pend_left_q;
    assign eff_right = i_btn_right | pend_right_q;
    assign eff_mode  = i_btn_mode  | pend_mode_q;

    assign pan_next  = step_pos(pan_q, eff_right, eff_left);
    assign tilt_next = step_pos(tilt_q, eff_up, eff_down);

    always_comb begin
        state_d      = state_q;
        pan_d        = pan_q;
        tilt_d       = tilt_q;
        cnt_d        = cnt_q;
        pend_up_d    = pend_up_q;
        pend_down_d  = pend_down_q;
        pend_left_d  = pend_left_q;
        pend_right_d = pend_right_q;
        pend_mode_d  = pend_mode_q;

        case (state_q)
            ST_AUTO: begin
                pend_up_d    = 1'b0;
                pend_down_d  = 1'b0;
                pend_left_d  = 1'b0;
                pend_right_d = 1'b0;
                pend_mode_d  = 1'b0;
                if (i_btn_mode) begin
                    pan_d   = CENTER8;
                    tilt_d  = CENTER8;
                    state_d = ST_SEND;
                end
            end
            ST_MANUAL: begin
                // Pending flags are consumed here whatever the outcome.
                pend_up_d    = 1'b0;
                pend_down_d  = 1'b0;
                pend_left_d  = 1'b0;
                pend_right_d = 1'b0;
                pend_mode_d  = 1'b0;
                if (eff_mode) begin
                    // Mode wins; direction presses in the same cycle are dropped.
                    state_d = ST_AUTO;
                end else if ((pan_next != pan_q) || (tilt_next != tilt_q)) begin
                    pan_d   = pan_next;
                    tilt_d  = tilt_next;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                pend_up_d    = pend_up_q    | i_btn_up;
                pend_down_d  = pend_down_q  | i_btn_down;
                pend_left_d  = pend_left_q  | i_btn_left;
                pend_right_d = pend_right_q | i_btn_right;
                pend_mode_d  = pend_mode_q  | i_btn_mode;
                if (i_ready) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = ST_MANUAL;
                end
            end
            default: begin
                state_d = ST_AUTO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_AUTO;
            pan_q        <= CENTER8;
            tilt_q       <= CENTER8;
            cnt_q        <= 8'd0;
            pend_up_q    <= 1'b0;
            pend_down_q  <= 1'b0;
            pend_left_q  <= 1'b0;
            pend_right_q <= 1'b0;
            pend_mode_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pan_q        <= pan_d;
            tilt_q       <= tilt_d;
            cnt_q        <= cnt_d;
            pend_up_q    <= pend_up_d;
            pend_down_q  <= pend_down_d;
            pend_left_q  <= pend_left_d;
            pend_right_q <= pend_right_d;
            pend_mode_q  <= pend_mode_d;
        end
    end

    assign o_valid   = (state_q == ST_SEND);
    assign o_mode    = (state_q != ST_AUTO);
    assign o_pan     = pan_q;
    assign o_tilt    = tilt_q;
    assign o_cmd_cnt = cnt_q;

endmodule

// File: tb/tb_btn_servo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_btn_servo_ctrl
//   Directed bench for btn_servo_ctrl. Inputs change 1 ns after a rising
//   edge and outputs are sampled there too, so every "tick" shows the
//   registered result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_btn_servo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_btn_up = 1'b0;
    logic       i_btn_down = 1'b0;
    logic       i_btn_left = 1'b0;
    logic       i_btn_right = 1'b0;
    logic       i_btn_mode = 1'b0;
    logic       i_ready = 1'b0;
    logic       o_valid;
    logic [7:0] o_pan;
    logic [7:0] o_tilt;
    logic       o_mode;
    logic [7:0] o_cmd_cnt;

    int checks = 0;
    int failures = 0;

    btn_servo_ctrl #(
        .STEP    (8),
        .POS_MIN (0),
        .POS_MAX (180),
        .CENTER  (90)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_btn_up    (i_btn_up),
        .i_btn_down  (i_btn_down),
        .i_btn_left  (i_btn_left),
        .i_btn_right (i_btn_right),
        .i_btn_mode  (i_btn_mode),
        .i_ready     (i_ready),
        .o_valid     (o_valid),
        .o_pan       (o_pan),
        .o_tilt      (o_tilt),
        .o_mode      (o_mode),
        .o_cmd_cnt   (o_cmd_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse on the selected buttons, seen by exactly one edge.
    task automatic press(input logic u, input logic d, input logic l,
                         input logic r, input logic m);
        i_btn_up    = u;
        i_btn_down  = d;
        i_btn_left  = l;
        i_btn_right = r;
        i_btn_mode  = m;
        tick();
        i_btn_up    = 1'b0;
        i_btn_down  = 1'b0;
        i_btn_left  = 1'b0;
        i_btn_right = 1'b0;
        i_btn_mode  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // AUTO -> SEND(center) -> accepted -> MANUAL
    task automatic enter_manual();
        i_ready = 1'b1;
        press(0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", o_valid); end
        checks++; if (o_mode !== 1'b0) begin failures++; $display("FAIL reset_mode: got %0b want 0", o_mode); end
        checks++; if (o_pan !== 8'd90) begin failures++; $display("FAIL reset_pan: got %0d want 90", o_pan); end
        checks++; if (o_tilt !== 8'd90) begin failures++; $display("FAIL reset_tilt: got %0d want 90", o_tilt); end
        checks++; if (o_cmd_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", o_cmd_cnt); end
        reset = 1'b1;
    endtask

    task automatic test_mode_entry();
        i_ready = 1'b1;
        press(0, 0, 0, 0, 1);
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL entry_valid: got %0b want 1", o_valid); end
        checks++; if (o_pan !== 8'd90 || o_tilt !== 8'd90) begin failures++; $display("FAIL entry_pos: got %0d/%0d want 90/90", o_pan, o_tilt); end
        checks++; if (o_mode !== 1'b1) begin failures++; $display("FAIL entry_mode_send: got %0b want 1", o_mode); end
        tick();
        checks++; if (o_cmd_cnt !== 8'd1) begin failures++; $display("FAIL entry_cnt: got %0d want 1", o_cmd_cnt); end
        checks++; if (o_valid !== 1'b0 || o_mode !== 1'b1) begin failures++; $display("FAIL entry_manual: got valid=%0b mode=%0b want 0/1", o_valid, o_mode); end
    endtask

    task automatic test_saturation();
        int exp_pos;
        i_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            exp_pos = 90 + 8 * i;
            if (exp_pos > 180) exp_pos = 180;
            press(0, 0, 0, 1, 0);
            checks++; if (o_valid !== 1'b1 || o_pan !== 8'(exp_pos)) begin failures++; $display("FAIL sat_pan_%0d: got valid=%0b pan=%0d want 1/%0d", i, o_valid, o_pan, exp_pos); end
            tick();
        end
        press(0, 0, 0, 1, 0);
        checks++; if (o_valid !== 1'b0 || o_pan !== 8'd180) begin failures++; $display("FAIL sat_pan_hold: got valid=%0b pan=%0d want 0/180", o_valid, o_pan); end
        for (int i = 1; i <= 12; i++) begin
            exp_pos = 90 - 8 * i;
            if (exp_pos < 0) exp_pos = 0;
            press(0, 1, 0, 0, 0);
            checks++; if (o_valid !== 1'b1 || o_tilt !== 8'(exp_pos)) begin failures++; $display("FAIL sat_tilt_%0d: got valid=%0b tilt=%0d want 1/%0d", i, o_valid, o_tilt, exp_pos); end
            tick();
        end
        press(0, 1, 0, 0, 0);
        checks++; if (o_valid !== 1'b0 || o_tilt !== 8'd0) begin failures++; $display("FAIL sat_tilt_hold: got valid=%0b tilt=%0d want 0/0", o_valid, o_tilt); end
        checks++; if (o_cmd_cnt !== 8'd25) begin failures++; $display("FAIL sat_cnt: got %0d want 25", o_cmd_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        enter_manual();
        i_ready = 1'b0;
        press(1, 0, 0, 0, 0);
        checks++; if (o_valid !== 1'b1 || o_tilt !== 8'd98 || o_pan !== 8'd90) begin failures++; $display("FAIL bp_first: got valid=%0b tilt=%0d pan=%0d want 1/98/90", o_valid, o_tilt, o_pan); end
        press(1, 0, 1, 0, 0);
        press(1, 0, 0, 0, 0);
        tick();
        tick();
        checks++; if (o_valid !== 1'b1 || o_tilt !== 8'd98 || o_pan !== 8'd90) begin failures++; $display("FAIL bp_hold: got valid=%0b tilt=%0d pan=%0d want 1/98/90", o_valid, o_tilt, o_pan); end
        i_ready = 1'b1;
        tick();
        checks++; if (o_valid !== 1'b0 || o_cmd_cnt !== 8'd2) begin failures++; $display("FAIL bp_accept: got valid=%0b cnt=%0d want 0/2", o_valid, o_cmd_cnt); end
        i_ready = 1'b0;
        tick();
        checks++; if (o_valid !== 1'b1 || o_tilt !== 8'd106 || o_pan !== 8'd82) begin failures++; $display("FAIL bp_pending: got valid=%0b tilt=%0d pan=%0d want 1/106/82", o_valid, o_tilt, o_pan); end
        i_ready = 1'b1;
        tick();
        checks++; if (o_cmd_cnt !== 8'd3 || o_valid !== 1'b0) begin failures++; $display("FAIL bp_cnt: got cnt=%0d valid=%0b want 3/0", o_cmd_cnt, o_valid); end
    endtask

    task automatic test_simultaneous();
        i_ready = 1'b1;
        press(1, 1, 0, 0, 0);
        checks++; if (o_valid !== 1'b0 || o_tilt !== 8'd106) begin failures++; $display("FAIL sim_updown: got valid=%0b tilt=%0d want 0/106", o_valid, o_tilt); end
        press(0, 1, 1, 1, 0);
        checks++; if (o_valid !== 1'b1 || o_pan !== 8'd82 || o_tilt !== 8'd98) begin failures++; $display("FAIL sim_lr_down: got valid=%0b pan=%0d tilt=%0d want 1/82/98", o_valid, o_pan, o_tilt); end
        tick();
        press(0, 0, 0, 1, 1);
        checks++; if (o_mode !== 1'b0 || o_valid !== 1'b0 || o_pan !== 8'd82) begin failures++; $display("FAIL sim_mode_right: got mode=%0b valid=%0b pan=%0d want 0/0/82", o_mode, o_valid, o_pan); end
        press(0, 0, 0, 1, 0);
        checks++; if (o_mode !== 1'b0 || o_valid !== 1'b0 || o_pan !== 8'd82) begin failures++; $display("FAIL auto_ignore: got mode=%0b valid=%0b pan=%0d want 0/0/82", o_mode, o_valid, o_pan); end
        press(0, 0, 0, 0, 1);
        checks++; if (o_valid !== 1'b1 || o_pan !== 8'd90 || o_tilt !== 8'd90) begin failures++; $display("FAIL auto_reentry: got valid=%0b pan=%0d tilt=%0d want 1/90/90", o_valid, o_pan, o_tilt); end
        tick();
        tick();
        checks++; if (o_valid !== 1'b0 || o_pan !== 8'd90 || o_cmd_cnt !== 8'd5) begin failures++; $display("FAIL auto_no_store: got valid=%0b pan=%0d cnt=%0d want 0/90/5", o_valid, o_pan, o_cmd_cnt); end
    endtask

    task automatic test_pending_mode();
        i_ready = 1'b0;
        press(0, 0, 0, 1, 0);
        press(0, 0, 0, 0, 1);
        checks++; if (o_valid !== 1'b1 || o_mode !== 1'b1 || o_pan !== 8'd98) begin failures++; $display("FAIL pmode_send: got valid=%0b mode=%0b pan=%0d want 1/1/98", o_valid, o_mode, o_pan); end
        i_ready = 1'b1;
        tick();
        checks++; if (o_valid !== 1'b0 || o_mode !== 1'b1 || o_cmd_cnt !== 8'd6) begin failures++; $display("FAIL pmode_accept: got valid=%0b mode=%0b cnt=%0d want 0/1/6", o_valid, o_mode, o_cmd_cnt); end
        tick();
        checks++; if (o_mode !== 1'b0 || o_valid !== 1'b0 || o_pan !== 8'd98) begin failures++; $display("FAIL pmode_auto: got mode=%0b valid=%0b pan=%0d want 0/0/98", o_mode, o_valid, o_pan); end
    endtask

    task automatic test_reset_mid_send();
        i_ready = 1'b0;
        press(0, 0, 0, 0, 1);
        press(1, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_mode !== 1'b0) begin failures++; $display("FAIL rst_send_ctl: got valid=%0b mode=%0b want 0/0", o_valid, o_mode); end
        checks++; if (o_pan !== 8'd90 || o_tilt !== 8'd90 || o_cmd_cnt !== 8'd0) begin failures++; $display("FAIL rst_send_data: got pan=%0d tilt=%0d cnt=%0d want 90/90/0", o_pan, o_tilt, o_cmd_cnt); end
        tick();
        reset = 1'b1;
        i_ready = 1'b1;
        press(0, 0, 0, 0, 1);
        checks++; if (o_valid !== 1'b1 || o_mode !== 1'b1) begin failures++; $display("FAIL rst_first_edge: got valid=%0b mode=%0b want 1/1", o_valid, o_mode); end
        tick();
        tick();
        checks++; if (o_valid !== 1'b0 || o_tilt !== 8'd90 || o_cmd_cnt !== 8'd1) begin failures++; $display("FAIL rst_pend_clr: got valid=%0b tilt=%0d cnt=%0d want 0/90/1", o_valid, o_tilt, o_cmd_cnt); end
    endtask

    task automatic test_counter_wrap();
        i_ready = 1'b1;
        for (int i = 1; i <= 254; i++) begin
            if (i % 2 == 1) press(0, 0, 0, 1, 0);
            else            press(0, 0, 1, 0, 0);
            tick();
        end
        checks++; if (o_cmd_cnt !== 8'd255) begin failures++; $display("FAIL wrap_255: got %0d want 255", o_cmd_cnt); end
        press(0, 0, 0, 1, 0);
        checks++; if (o_valid !== 1'b1 || o_pan !== 8'd98) begin failures++; $display("FAIL wrap_last_cmd: got valid=%0b pan=%0d want 1/98", o_valid, o_pan); end
        tick();
        checks++; if (o_cmd_cnt !== 8'd0) begin failures++; $display("FAIL wrap_zero: got %0d want 0", o_cmd_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        test_reset();
        test_mode_entry();
        test_saturation();
        test_backpressure();
        test_simultaneous();
        test_pending_mode();
        test_reset_mid_send();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
